// File: rtl/svc_rv_pkg.sv
// Shared types and helpers for the svc_rv core: mul/div sequencing states
// and the register-operand match used by hazard detection.
package svc_rv_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // A source depends on a producer only if it is really read, is not x0,
    // and the producer really writes that same register.
    function automatic logic src_match(
        input logic                 used,
        input logic [REG_IDX_W-1:0] rs,
        input logic                 wr,
        input logic [REG_IDX_W-1:0] rd
    );
        return used && (rs != '0) && wr && (rd == rs);
    endfunction

endpackage

// File: rtl/svc_rv_hazard_detect.sv
// Combinational RAW hazard detect between the ID consumer and the EX/MEM/WB
// producers; FWD selects which hazards forwarding can already cover.
module svc_rv_hazard_detect
    import svc_rv_pkg::*;
#(
    parameter int FWD = 0
) (
    input  logic       [4:0] rs1_id,
    input  logic       [4:0] rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic       [4:0] rd_ex,
    input  logic             reg_write_ex,
    input  logic             is_load_ex,
    input  logic             is_csr_ex,
    input  logic       [4:0] rd_mem,
    input  logic             reg_write_mem,
    input  logic       [4:0] rd_wb,
    input  logic             reg_write_wb,
    output logic             dh
);

    localparam logic HAS_FWD = (FWD != 0);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        ex_hit  = src_match(rs1_used_id, rs1_id, reg_write_ex, rd_ex)
               || src_match(rs2_used_id, rs2_id, reg_write_ex, rd_ex);
        mem_hit = src_match(rs1_used_id, rs1_id, reg_write_mem, rd_mem)
               || src_match(rs2_used_id, rs2_id, reg_write_mem, rd_mem);
        wb_hit  = src_match(rs1_used_id, rs1_id, reg_write_wb, rd_wb)
               || src_match(rs2_used_id, rs2_id, reg_write_wb, rd_wb);
        // Forwarding only fails when the EX result is not yet known (load/CSR);
        // without it every in-flight producer blocks, regfile has no write-through.
        dh = HAS_FWD ? (ex_hit && (is_load_ex || is_csr_ex))
                     : (ex_hit || mem_hit || wb_hit);
    end

endmodule

// File: rtl/svc_rv_hazard.sv
// Pipeline hazard controller: stall/flush priority, mul/div start/done
// sequencing and stall/flush performance counters.
module svc_rv_hazard
    import svc_rv_pkg::*;
#(
    parameter int FWD   = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             reg_write_ex,
    input  logic             is_load_ex,
    input  logic             is_csr_ex,
    input  logic [4:0]       rd_mem,
    input  logic             reg_write_mem,
    input  logic [4:0]       rd_wb,
    input  logic             reg_write_wb,
    input  logic             redirect_ex,
    input  logic             md_valid_ex,
    input  logic             md_done,
    output logic             md_start,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       md_state
);

    md_state_t state_q;
    md_state_t state_d;
    logic      dh;
    logic      md_stall;
    logic      md_kick;

    svc_rv_hazard_detect #(.FWD(FWD)) u_detect (
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_used_id   (rs1_used_id),
        .rs2_used_id   (rs2_used_id),
        .rd_ex         (rd_ex),
        .reg_write_ex  (reg_write_ex),
        .is_load_ex    (is_load_ex),
        .is_csr_ex     (is_csr_ex),
        .rd_mem        (rd_mem),
        .reg_write_mem (reg_write_mem),
        .rd_wb         (rd_wb),
        .reg_write_wb  (reg_write_wb),
        .dh            (dh)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= MD_IDLE;
        else        state_q <= state_d;
    end

    // MD_DONE is a one-cycle guard so the op still sitting in EX is not restarted.
    always_comb begin
        state_d  = state_q;
        md_stall = 1'b0;
        md_kick  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_valid_ex) begin
                    md_stall = 1'b1;
                    md_kick  = 1'b1;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_stall = 1'b1;
                if (md_done) state_d = MD_DONE;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // EX frozen by mul/div masks everything; a redirect discards the ID
    // instruction, so its data hazard no longer matters.
    always_comb begin
        md_start     = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (rst_n) begin
            if (md_stall) begin
                md_start     = md_kick;
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (redirect_ex) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (dh) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_if_id) stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect_ex) flush_count  <= flush_count + CNT_W'(1);
        end
    end

    assign md_state = state_q;

endmodule

// File: tb/tb_svc_rv_hazard.sv
// Bench for svc_rv_hazard: one forwarding and one stall-only instance on
// shared inputs, checked cycle by cycle against a behavioural model.
module tb_svc_rv_hazard;
    import svc_rv_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem, rd_wb;
    logic       rs1_used_id, rs2_used_id;
    logic       reg_write_ex, is_load_ex, is_csr_ex, reg_write_mem, reg_write_wb;
    logic       redirect_ex, md_valid_ex, md_done;

    logic [6:0]    ctl_f1, ctl_f0;
    logic [CW-1:0] sc_f1, fc_f1, sc_f0, fc_f0;
    logic [1:0]    st_f1, st_f0;

    svc_rv_hazard #(.FWD(1), .CNT_W(CW)) dut_f1 (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .is_load_ex(is_load_ex),
        .is_csr_ex(is_csr_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .redirect_ex(redirect_ex),
        .md_valid_ex(md_valid_ex), .md_done(md_done), .md_start(ctl_f1[0]),
        .stall_pc(ctl_f1[6]), .stall_if_id(ctl_f1[5]), .stall_id_ex(ctl_f1[4]),
        .flush_if_id(ctl_f1[3]), .flush_id_ex(ctl_f1[2]), .flush_ex_mem(ctl_f1[1]),
        .stall_cycles(sc_f1), .flush_count(fc_f1), .md_state(st_f1)
    );

    svc_rv_hazard #(.FWD(0), .CNT_W(CW)) dut_f0 (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .is_load_ex(is_load_ex),
        .is_csr_ex(is_csr_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .redirect_ex(redirect_ex),
        .md_valid_ex(md_valid_ex), .md_done(md_done), .md_start(ctl_f0[0]),
        .stall_pc(ctl_f0[6]), .stall_if_id(ctl_f0[5]), .stall_id_ex(ctl_f0[4]),
        .flush_if_id(ctl_f0[3]), .flush_id_ex(ctl_f0[2]), .flush_ex_mem(ctl_f0[1]),
        .stall_cycles(sc_f0), .flush_count(fc_f0), .md_state(st_f0)
    );

    always @(posedge clk)
        if (rst_n) assert (!(redirect_ex && md_valid_ex))
            else $error("redirect_ex and md_valid_ex asserted together");

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a mul/div op is "in flight" from its start until md_done, and the
    // cycle after completion is a cooldown where the same op cannot restart.
    bit m_busy, m_cool;
    int m_sc1, m_sc0, m_fc;
    logic [6:0] obs_f1;

    function automatic bit model_dh(input bit fwd);
        logic [4:0] prd[3];
        logic       pwr[3];
        bit hit;
        prd = '{rd_ex, rd_mem, rd_wb};
        pwr = '{reg_write_ex, reg_write_mem, reg_write_wb};
        for (int p = 0; p < 3; p++) begin
            hit = pwr[p] && ((rs1_used_id && rs1_id != 0 && rs1_id == prd[p]) ||
                             (rs2_used_id && rs2_id != 0 && rs2_id == prd[p]));
            if (hit && !fwd) return 1'b1;
            if (hit && fwd && p == 0 && (is_load_ex || is_csr_ex)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Bit order: stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, md_start
    function automatic logic [6:0] exp_ctl(input bit fwd);
        bit start;
        if (!rst_n) return 7'b0;
        start = !m_busy && !m_cool && md_valid_ex;
        if (m_busy || start) return {6'b111001, start};
        if (redirect_ex)     return 7'b0001100;
        if (model_dh(fwd))   return 7'b1100100;
        return 7'b0;
    endfunction

    task automatic step();
        logic [6:0] e1, e0;
        @(negedge clk);
        e1 = exp_ctl(1'b1);
        e0 = exp_ctl(1'b0);
        obs_f1 = ctl_f1;
        check("ctl_fwd1", 32'(ctl_f1), 32'(e1));
        check("ctl_fwd0", 32'(ctl_f0), 32'(e0));
        check("stall_cnt_fwd1", 32'(sc_f1), 32'(m_sc1));
        check("stall_cnt_fwd0", 32'(sc_f0), 32'(m_sc0));
        check("flush_cnt_fwd1", 32'(fc_f1), 32'(m_fc));
        check("flush_cnt_fwd0", 32'(fc_f0), 32'(m_fc));
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_cool = 0; m_sc1 = 0; m_sc0 = 0; m_fc = 0;
        end else begin
            if (e1[5]) m_sc1 = (m_sc1 + 1) % (1 << CW);
            if (e0[5]) m_sc0 = (m_sc0 + 1) % (1 << CW);
            if (redirect_ex) m_fc = (m_fc + 1) % (1 << CW);
            if (m_busy) begin
                if (md_done) begin m_busy = 0; m_cool = 1; end
            end else if (m_cool) m_cool = 0;
            else if (md_valid_ex) m_busy = 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
        rd_ex = 0; reg_write_ex = 0; is_load_ex = 0; is_csr_ex = 0;
        rd_mem = 0; reg_write_mem = 0; rd_wb = 0; reg_write_wb = 0;
        redirect_ex = 0; md_valid_ex = 0; md_done = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; step(); step();
        rst_n = 1;
    endtask

    int stalls, starts;

    initial begin
        idle_inputs();
        do_reset();
        check("reset_state", 32'(st_f1), 32'(MD_IDLE));

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID; then load moves on
        rs1_id = 5; rs1_used_id = 1; rs2_id = 1; rs2_used_id = 1;
        rd_ex = 5; reg_write_ex = 1; is_load_ex = 1;
        step();
        check("load_use_stall", 32'(obs_f1), 32'b1100100);
        rd_ex = 0; reg_write_ex = 0; is_load_ex = 0; rd_mem = 5; reg_write_mem = 1;
        step();
        check("load_use_release", 32'(obs_f1), 32'b0);
        check("load_use_count", 32'(sc_f1), 32'd1);

        // Back-to-back x7 dependency walking EX -> MEM -> WB -> retired
        idle_inputs(); do_reset();
        rs1_id = 7; rs1_used_id = 1; rd_ex = 7; reg_write_ex = 1;
        step();
        rd_ex = 0; reg_write_ex = 0; rd_mem = 7; reg_write_mem = 1;
        step();
        rd_mem = 0; reg_write_mem = 0; rd_wb = 7; reg_write_wb = 1;
        step();
        rd_wb = 0; reg_write_wb = 0;
        step();
        check("nofwd_3stall", 32'(sc_f0), 32'd3);
        check("fwd_alu_nostall", 32'(sc_f1), 32'd0);
        // x0 source and unused source never stall
        rs1_id = 0; rd_ex = 0; reg_write_ex = 1; step();
        rs1_id = 7; rs1_used_id = 0; rd_ex = 7; step();
        check("x0_unused_nostall", 32'(sc_f0), 32'd3);

        // Redirect together with a load-use hazard
        idle_inputs(); do_reset();
        rs1_id = 5; rs1_used_id = 1; rd_ex = 5; reg_write_ex = 1; is_load_ex = 1;
        redirect_ex = 1;
        step();
        check("redirect_over_dh", 32'(obs_f1), 32'b0001100);
        idle_inputs(); step();
        check("redirect_count", 32'(fc_f1), 32'd1);

        // Mul/div with md_done 4 cycles after md_start
        stalls = 0; starts = 0;
        md_valid_ex = 1;
        for (int c = 0; c < 6; c++) begin
            md_done = (c == 4);
            step();
            stalls += obs_f1[5];
            starts += obs_f1[0];
        end
        check("md_done_state", 32'(st_f1), 32'(MD_IDLE));
        md_valid_ex = 0; md_done = 0; step();
        check("md_stall_cycles", 32'(stalls), 32'd5);
        check("md_start_once", 32'(starts), 32'd1);

        // Reset while busy
        md_valid_ex = 1; step(); step();
        check("md_busy_state", 32'(st_f0), 32'(MD_BUSY));
        rst_n = 0; step();
        rst_n = 1; md_valid_ex = 0;
        check("rst_busy_state", 32'(st_f0), 32'(MD_IDLE));
        step();

        // Counter wrap: 17 stall cycles on a 4-bit counter ends at 1
        rs1_id = 3; rs1_used_id = 1; rd_ex = 3; reg_write_ex = 1; is_csr_ex = 1;
        for (int c = 0; c < 17; c++) step();
        check("stall_wrap", 32'(sc_f1), 32'd1);
        idle_inputs(); do_reset();

        // Randomized traffic with small register indices to provoke matches
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
            rs1_used_id = 1'($urandom); rs2_used_id = 1'($urandom);
            rd_ex = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
            rd_wb = 5'($urandom_range(0, 3));
            reg_write_ex = 1'($urandom); reg_write_mem = 1'($urandom);
            reg_write_wb = 1'($urandom);
            is_load_ex = ($urandom_range(0, 2) == 0); is_csr_ex = ($urandom_range(0, 4) == 0);
            if (m_busy) begin
                md_valid_ex = 1; redirect_ex = 0;
                md_done = ($urandom_range(0, 3) == 0);
            end else begin
                md_valid_ex = ($urandom_range(0, 5) == 0);
                redirect_ex = !md_valid_ex && ($urandom_range(0, 4) == 0);
                md_done = ($urandom_range(0, 5) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
